// File: rtl/messbauer_pkg.sv
// Shared definitions for the Moessbauer spectrometer sequencing blocks.
//   state_t              : sequence controller state encoding (3 bits)
//   MAX_CHANNEL_NUMBER   : largest channel count a measurement cycle may use
//   CHANNEL_INDEX_WIDTH  : width of the per-cycle channel index
//   GEN_*_IDLE           : levels the generator holds on its outputs while in reset
//   is_pow2()            : parameter sanity helper
package messbauer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RUN        = 3'd3,
        ST_FINISH     = 3'd4
    } state_t;

    localparam int MAX_CHANNEL_NUMBER  = 4096;
    localparam int CHANNEL_INDEX_WIDTH = 12;

    // Generator output levels while it is held in reset; the start strobe
    // and the channel strobe are both active-low pulses.
    localparam logic GEN_START_IDLE   = 1'b1;
    localparam logic GEN_CHANNEL_IDLE = 1'b1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Registered edge detector for a signal already in the aclk domain.
//   aclk, areset : clock and synchronous active-high reset
//   sig          : input level
//   rise, fall   : one-cycle pulses, asserted one aclk after sig changes
// RESET_VALUE is the level assumed for sig before reset is released, so a
// source sitting at its idle level produces no edge when reset drops.
module edge_detector #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic aclk,
    input  logic areset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_reg;
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sig_reg  <= RESET_VALUE;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sig_reg  <= sig;
            rise_reg <= sig & ~sig_reg;
            fall_reg <= ~sig & sig_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/messbauer_sequence_controller.sv
// Sequences a Moessbauer channel generator through arm / start / run.
//   aclk, areset      : clock, synchronous active-high reset
//   cmd_run, cmd_stop : one-cycle command pulses (run wins if both in IDLE)
//   cycles_to_run     : measurement cycles to run, 0 = until stopped
//   gen_start         : generator start strobe (falling edge = cycle start)
//   gen_channel       : generator channel strobe (rising edge = next channel)
//   gen_enable        : generator active-low reset, 1 = generator runs
//   busy, done        : run in progress / one-cycle completion pulse
//   aborted, error    : run was stopped / sticky sequence error
//   cycle_count       : completed measurement cycles
//   channel_index     : channels seen in the current cycle
module messbauer_sequence_controller
    import messbauer_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 512,
    parameter int ARM_DURATION   = 16,
    parameter int START_TIMEOUT  = 1000000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_run,
    input  logic        cmd_stop,
    input  logic [15:0] cycles_to_run,
    input  logic        gen_start,
    input  logic        gen_channel,
    output logic        gen_enable,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        error,
    output logic [15:0] cycle_count,
    output logic [11:0] channel_index
);

    if (!is_pow2(CHANNEL_NUMBER) || CHANNEL_NUMBER > MAX_CHANNEL_NUMBER) begin : g_bad_channel_number
        $error("CHANNEL_NUMBER must be a power of two not above MAX_CHANNEL_NUMBER");
    end

    // One bit wider than the index so a full 4096-channel cycle is representable.
    localparam logic [12:0] CHANNEL_LAST = 13'(CHANNEL_NUMBER);
    localparam logic [31:0] ARM_LAST     = 32'(ARM_DURATION - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(START_TIMEOUT);
    localparam logic [11:0] INDEX_MAX    = 12'hFFF;
    localparam logic [1:0]  EDGE_IDLE    = {GEN_CHANNEL_IDLE, GEN_START_IDLE};

    // ---------------- edge detection: bit 0 = start, bit 1 = channel
    logic [1:0] edge_in;
    logic [1:0] edge_rise;
    logic [1:0] edge_fall;
    logic       start_fall;
    logic       chan_rise;
    logic       unused_edges;

    assign edge_in = {gen_channel, gen_start};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_edge
        edge_detector #(
            .RESET_VALUE(EDGE_IDLE[gi])
        ) u_edge (
            .aclk  (aclk),
            .areset(areset),
            .sig   (edge_in[gi]),
            .rise  (edge_rise[gi]),
            .fall  (edge_fall[gi])
        );
    end

    assign start_fall   = edge_fall[0];
    assign chan_rise    = edge_rise[1];
    assign unused_edges = edge_rise[0] | edge_fall[1];

    // ---------------- state
    state_t      state_reg,         state_next;
    logic [31:0] timer_reg,         timer_next;
    logic [15:0] target_reg,        target_next;
    logic [15:0] cycle_count_reg,   cycle_count_next;
    logic [11:0] channel_index_reg, channel_index_next;
    logic        error_reg,         error_next;
    logic        aborted_reg,       aborted_next;
    // Set once the current cycle has seen all its channels; distinguishes a
    // legitimate next start (no error) from a premature one, and flags overrun.
    logic        full_reg,          full_next;
    logic [12:0] index_inc;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg         <= ST_IDLE;
            timer_reg         <= '0;
            target_reg        <= '0;
            cycle_count_reg   <= '0;
            channel_index_reg <= '0;
            error_reg         <= 1'b0;
            aborted_reg       <= 1'b0;
            full_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            target_reg        <= target_next;
            cycle_count_reg   <= cycle_count_next;
            channel_index_reg <= channel_index_next;
            error_reg         <= error_next;
            aborted_reg       <= aborted_next;
            full_reg          <= full_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        timer_next         = timer_reg;
        target_next        = target_reg;
        cycle_count_next   = cycle_count_reg;
        channel_index_next = channel_index_reg;
        error_next         = error_reg;
        aborted_next       = aborted_reg;
        full_next          = full_reg;
        index_inc          = '0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_run) begin
                    state_next         = ST_ARM;
                    target_next        = cycles_to_run;
                    timer_next         = '0;
                    cycle_count_next   = '0;
                    channel_index_next = '0;
                    error_next         = 1'b0;
                    aborted_next       = 1'b0;
                    full_next          = 1'b0;
                end
            end

            ST_ARM: begin
                if (cmd_stop) begin
                    state_next   = ST_FINISH;
                    aborted_next = 1'b1;
                end else if (timer_reg == ARM_LAST) begin
                    state_next = ST_WAIT_START;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end

            ST_WAIT_START: begin
                if (cmd_stop) begin
                    state_next   = ST_FINISH;
                    aborted_next = 1'b1;
                end else if (start_fall) begin
                    state_next         = ST_RUN;
                    channel_index_next = '0;
                    full_next          = 1'b0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = ST_FINISH;
                    error_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end

            ST_RUN: begin
                if (cmd_stop) begin
                    state_next   = ST_FINISH;
                    aborted_next = 1'b1;
                end else begin
                    // Start is handled before channel so a coincident channel
                    // edge becomes channel 1 of the new cycle.
                    if (start_fall) begin
                        if (channel_index_reg != '0 && !full_reg) begin
                            error_next = 1'b1;
                        end
                        channel_index_next = '0;
                        full_next          = 1'b0;
                    end
                    if (chan_rise) begin
                        if (full_next) begin
                            error_next = 1'b1;
                        end else begin
                            index_inc = {1'b0, channel_index_next} + 13'd1;
                            if (channel_index_next != INDEX_MAX) begin
                                channel_index_next = index_inc[11:0];
                            end
                            if (index_inc == CHANNEL_LAST) begin
                                full_next        = 1'b1;
                                cycle_count_next = cycle_count_reg + 16'd1;
                                if (target_reg != '0 && cycle_count_next == target_reg) begin
                                    state_next = ST_FINISH;
                                end
                            end
                        end
                    end
                end
            end

            ST_FINISH: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign gen_enable    = (state_reg == ST_WAIT_START) || (state_reg == ST_RUN);
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_FINISH);
    assign aborted       = aborted_reg;
    assign error         = error_reg;
    assign cycle_count   = cycle_count_reg;
    assign channel_index = channel_index_reg;

endmodule

// File: tb/tb_messbauer_sequence_controller.sv
// Directed bench for messbauer_sequence_controller with a behavioural
// channel generator (8 channels, start pulse then one channel every 4 aclk).
module tb_messbauer_sequence_controller;

    localparam int CN          = 8;
    localparam int GEN_PERIOD  = 4 * (CN + 1);
    localparam int GEN_NORMAL  = 0;
    localparam int GEN_INJECT  = 1;
    localparam int GEN_STUCK   = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_run = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [15:0] cycles_to_run = '0;
    logic        gen_start = 1'b1;
    logic        gen_channel = 1'b1;
    logic        gen_enable;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        error;
    logic [15:0] cycle_count;
    logic [11:0] channel_index;

    int tests_run = 0;
    int tests_failed = 0;
    int gen_mode = GEN_NORMAL;
    int ph = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    logic ch_prev = 1'b1;

    messbauer_sequence_controller #(
        .CHANNEL_NUMBER(CN),
        .ARM_DURATION  (16),
        .START_TIMEOUT (100)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .cmd_run      (cmd_run),
        .cmd_stop     (cmd_stop),
        .cycles_to_run(cycles_to_run),
        .gen_start    (gen_start),
        .gen_channel  (gen_channel),
        .gen_enable   (gen_enable),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .error        (error),
        .cycle_count  (cycle_count),
        .channel_index(channel_index)
    );

    initial forever #5 aclk = ~aclk;

    // Generator model, held in reset while gen_enable is low.
    always @(posedge aclk) begin
        if (!gen_enable) begin
            gen_start   <= 1'b1;
            gen_channel <= 1'b1;
            ph          <= 0;
            cyc         <= 0;
        end else begin
            if (gen_mode == GEN_STUCK) begin
                gen_start   <= 1'b1;
                gen_channel <= 1'b1;
            end else begin
                gen_start   <= !((ph < 2) || (gen_mode == GEN_INJECT && cyc == 0 && ph == 18));
                gen_channel <= !(ph >= 4 && ph % 4 == 0);
            end
            if (ph == GEN_PERIOD - 1) begin
                ph  <= 0;
                cyc <= cyc + 1;
            end else begin
                ph <= ph + 1;
            end
        end
    end

    always @(negedge aclk) begin
        if (done) done_cnt++;
        if (gen_channel && !ch_prev) rise_cnt++;
        ch_prev = gen_channel;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] %s ok (%0d)", tag, obs);
        end
    endtask

    task automatic pulse_run(input logic [15:0] n);
        @(negedge aclk);
        cycles_to_run = n;
        cmd_run = 1'b1;
        @(negedge aclk);
        cmd_run = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < max && !seen) begin
            @(negedge aclk);
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_pos(input logic [15:0] cc, input logic [11:0] idx, input int max, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < max && !seen) begin
            @(negedge aclk);
            n++;
            if (busy && cycle_count == cc && channel_index == idx) seen = 1'b1;
        end
    endtask

    initial begin
        int  n;
        int  arm_len;
        int  rise_base;
        int  done_base;
        bit  seen;

        // ---------------- reset state
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        check("reset_flags", 32'({gen_enable, busy, done, aborted, error}), 32'd0);
        check("reset_counts", 32'({cycle_count, channel_index}), 32'd0);

        // ---------------- cmd_stop in IDLE is ignored
        @(negedge aclk);
        cmd_stop = 1'b1;
        @(negedge aclk);
        cmd_stop = 1'b0;
        check("idle_stop_ignored", 32'({busy, done, aborted}), 32'd0);

        // ---------------- two full cycles with the generator
        rise_base = rise_cnt;
        pulse_run(16'd2);
        arm_len = 0;
        n = 0;
        while (!gen_enable && n < 200) begin
            if (busy) arm_len++;
            n++;
            @(negedge aclk);
        end
        check("arm_len", 32'(arm_len), 32'd16);
        wait_done(1000, n, seen);
        check("run2_done", 32'(seen), 32'd1);
        check("run2_rises", 32'(rise_cnt - rise_base), 32'd16);
        check("run2_cc", 32'(cycle_count), 32'd2);
        check("run2_idx", 32'(channel_index), 32'd8);
        check("run2_err_abort", 32'({error, aborted}), 32'd0);
        @(negedge aclk);
        check("run2_done_1cyc", 32'({busy, done}), 32'd0);

        // ---------------- endless run stopped after 3 cycles + 5 channels
        pulse_run(16'd0);
        wait_pos(16'd3, 12'd5, 3000, seen);
        check("stop_reach", 32'(seen), 32'd1);
        cmd_stop = 1'b1;
        @(negedge aclk);
        cmd_stop = 1'b0;
        check("stop_done", 32'(done), 32'd1);
        check("stop_abort", 32'(aborted), 32'd1);
        check("stop_cc", 32'(cycle_count), 32'd3);
        check("stop_idx", 32'(channel_index), 32'd5);
        check("stop_err", 32'(error), 32'd0);

        // ---------------- start never arrives
        gen_mode = GEN_STUCK;
        pulse_run(16'd1);
        n = 0;
        while (!gen_enable && n < 100) begin
            n++;
            @(negedge aclk);
        end
        check("tmo_wait_entry", 32'(gen_enable), 32'd1);
        n = 0;
        while (!done && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("tmo_latency_101_103", 32'(n >= 101 && n <= 103), 32'd1);
        check("tmo_err", 32'(error), 32'd1);
        check("tmo_cc", 32'(cycle_count), 32'd0);
        check("tmo_abort", 32'(aborted), 32'd0);

        // ---------------- premature start at channel 4
        gen_mode = GEN_INJECT;
        pulse_run(16'd2);
        n = 0;
        while (!error && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("inj_err", 32'(error), 32'd1);
        check("inj_idx_restart", 32'(channel_index), 32'd0);
        wait_done(1000, n, seen);
        check("inj_done", 32'(seen), 32'd1);
        check("inj_cc", 32'(cycle_count), 32'd2);
        check("inj_abort", 32'(aborted), 32'd0);

        // ---------------- reset mid-run
        gen_mode = GEN_NORMAL;
        pulse_run(16'd2);
        wait_pos(16'd0, 12'd3, 500, seen);
        check("rst_reach", 32'(seen), 32'd1);
        done_base = done_cnt;
        areset = 1'b1;
        @(negedge aclk);
        check("rst_flags", 32'({gen_enable, busy, done, aborted, error}), 32'd0);
        check("rst_counts", 32'({cycle_count, channel_index}), 32'd0);
        areset = 1'b0;
        repeat (5) @(negedge aclk);
        check("rst_no_done", 32'(done_cnt - done_base), 32'd0);
        pulse_run(16'd1);
        wait_done(1000, n, seen);
        check("rst_rerun_done", 32'(seen), 32'd1);
        check("rst_rerun_cc", 32'(cycle_count), 32'd1);
        check("rst_rerun_err", 32'({error, aborted}), 32'd0);

        // ---------------- run + stop together, mid-run run/target change
        @(negedge aclk);
        cycles_to_run = 16'd2;
        cmd_run = 1'b1;
        cmd_stop = 1'b1;
        @(negedge aclk);
        cmd_run = 1'b0;
        cmd_stop = 1'b0;
        check("both_arm", 32'({busy, gen_enable, aborted}), 32'b100);
        wait_pos(16'd0, 12'd2, 500, seen);
        check("both_reach_run", 32'(seen), 32'd1);
        pulse_run(16'd5);
        wait_done(1000, n, seen);
        check("both_done", 32'(seen), 32'd1);
        check("both_cc", 32'(cycle_count), 32'd2);
        check("both_err_abort", 32'({error, aborted}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
